// File: rtl/arb_pkg.sv
// Shared constants and types for the requester-queue / arbiter front end.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int GNT_W   = 2;

  typedef logic [GNT_W-1:0] gnt_idx_t;

endpackage

// File: rtl/arb_req_fifo.sv
// One requester queue: a DEPTH-entry circular FIFO with an occupancy count.
// The parent gates push and pop, so this block trusts them.
module arb_req_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              din,
  output logic [DW-1:0]              dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign dout = mem[rd_ptr];

  // Storage array has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/arb_req_queue.sv
// Four requester queues feeding a registered-grant round-robin arbiter.
// Requests are masked by the grant already in flight so an entry is never
// asked for twice; a granted entry is popped and presented for one cycle.
module arb_req_queue
  import arb_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                  arb_clk,
  input  logic                  arb_rst,
  input  logic [NUM_REQ-1:0]    in_valid,
  input  logic [NUM_REQ*DW-1:0] in_data,
  output logic [NUM_REQ-1:0]    in_ready,
  output logic                  arb_req0,
  output logic                  arb_req1,
  output logic                  arb_req2,
  output logic                  arb_req3,
  input  logic [GNT_W-1:0]      arb_gnt,
  output logic                  out_valid,
  output logic [GNT_W-1:0]      out_id,
  output logic [DW-1:0]         out_data,
  output logic                  gnt_err
);

  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0]      count     [NUM_REQ];
  logic [CW-1:0]      eff_count [NUM_REQ];
  logic [DW-1:0]      head      [NUM_REQ];
  logic [NUM_REQ-1:0] push_en;
  logic [NUM_REQ-1:0] pop_en;
  logic [NUM_REQ-1:0] req;
  logic               gnt_pending;
  logic               gnt_hit;
  gnt_idx_t           gnt_idx;

  assign gnt_idx = gnt_idx_t'(arb_gnt);
  assign gnt_hit = gnt_pending && (count[gnt_idx] != '0);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    logic pend_here;

    assign in_ready[i] = (count[i] < CW'(DEPTH));
    assign push_en[i]  = in_valid[i] & in_ready[i];
    assign pop_en[i]   = gnt_hit && (gnt_idx == gnt_idx_t'(i));
    // Subtract the in-flight grant only when there is something to take,
    // so a bogus grant to an empty queue cannot wrap the effective count.
    assign pend_here    = gnt_pending && (gnt_idx == gnt_idx_t'(i)) && (count[i] != '0);
    assign eff_count[i] = count[i] - CW'(pend_here);
    assign req[i]       = (eff_count[i] != '0);

    arb_req_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (arb_clk),
      .rst   (arb_rst),
      .push  (push_en[i]),
      .pop   (pop_en[i]),
      .din   (in_data[i*DW +: DW]),
      .dout  (head[i]),
      .count (count[i])
    );
  end

  assign arb_req0 = req[0];
  assign arb_req1 = req[1];
  assign arb_req2 = req[2];
  assign arb_req3 = req[3];

  // Grant qualification, dispatch register and sticky bad-grant flag.
  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) begin
      gnt_pending <= 1'b0;
      out_valid   <= 1'b0;
      out_id      <= '0;
      out_data    <= '0;
      gnt_err     <= 1'b0;
    end else begin
      gnt_pending <= |req;
      out_valid   <= gnt_hit;
      if (gnt_hit) begin
        out_id   <= gnt_idx;
        out_data <= head[gnt_idx];
      end
      if (gnt_pending && !gnt_hit) gnt_err <= 1'b1;
    end
  end

endmodule

// File: doc/arb_req_queue.md
ARB_REQ_QUEUE -- requirements
Module: arb_req_queue

Interface
REQ-001 SHALL have parameter DW, default 8: payload width per request entry.
REQ-002 SHALL have parameter DEPTH, default 4: entries per requester queue, a power of two and at least 2.
REQ-003 SHALL have port arb_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port arb_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 4 bits: per-requester push strobe.
REQ-006 SHALL have port in_data, input, 4xDW bits: per-requester payload, where lane i is bits [i*DW +: DW].
REQ-007 SHALL have port in_ready, output, 4 bits: per-requester queue not full.
REQ-008 SHALL have ports arb_req0, arb_req1, arb_req2 and arb_req3, each output, 1 bit: request lines to the downstream round-robin arbiter.
REQ-009 SHALL have port arb_gnt, input, 2 bits: registered grant index returned by the arbiter.
REQ-010 SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a dispatched entry.
REQ-011 SHALL have port out_id, output, 2 bits: index of the requester that was dispatched.
REQ-012 SHALL have port out_data, output, DW bits: payload of the dispatched entry.
REQ-013 SHALL have port gnt_err, output, 1 bit: sticky flag for a grant that pointed at an empty queue.

Function
REQ-014 SHALL keep four independent FIFO queues, each DEPTH entries deep, each with a count of width clog2(DEPTH+1).
REQ-015 SHALL push lane i on a rising edge where in_valid[i] and in_ready[i] are both 1; in_valid[i] while in_ready[i]=0 SHALL be ignored with no state change.
REQ-016 SHALL drive in_ready[i] = (count[i] < DEPTH) from the registered count only, so a full queue refuses a push even when a pop happens in the same cycle.
REQ-017 SHALL register gnt_pending <= (arb_req0|arb_req1|arb_req2|arb_req3) every cycle; arb_gnt is qualified only while gnt_pending=1.
REQ-018 SHALL define eff_count[i] = count[i] - (gnt_pending && arb_gnt==i), and drive arb_reqi = (eff_count[i] != 0) combinationally.
REQ-019 SHALL, when gnt_pending=1 and count[arb_gnt]!=0, on that edge pop the head of queue arb_gnt, load out_data with the head value and out_id with arb_gnt, and set out_valid=1 for exactly the next cycle.
REQ-020 SHALL give a latency of 2 cycles from arb_reqi rising to out_valid, assuming the arbiter grants i on its first sampling edge.
REQ-021 SHALL, when gnt_pending=1 and count[arb_gnt]==0, pop nothing, leave out_valid=0, and set gnt_err=1 until reset.
REQ-022 SHALL allow a push and a pop on the same queue in the same cycle; count is unchanged and FIFO order is kept.
REQ-023 SHALL wrap the read and write pointers modulo DEPTH.
REQ-024 SHALL hold out_data and out_id at their last values while out_valid=0.
REQ-025 SHALL never apply backpressure on the output; a consumer must accept every out_valid pulse.

Reset
REQ-026 SHALL, while arb_rst=1, immediately clear all counts and pointers, gnt_pending, out_valid, out_id, out_data and gnt_err to 0; arb_req0-3 therefore read 0 and in_ready reads 4'b1111.
REQ-027 SHALL, on reset asserted mid-operation, discard all queued entries and any in-flight dispatch, with no out_valid pulse after reset is released.

Structure
REQ-028 SHALL take NUM_REQ=4, GNT_W=2 and a gnt_idx_t typedef from the shared package arb_pkg.
REQ-029 SHALL build each queue as the sub-module arb_req_fifo (parameters DW and DEPTH; ports push, pop, din, dout, count), instantiated four times.
REQ-030 SHALL keep the dispatch, qualification and error logic in arb_req_queue itself.

Verification
REQ-031 Single dispatch SHALL be covered: push 8'hA5 on lane 2 at cycle 0 -> arb_req2=1 at cycle 1; bench grants 2; arb_req2=0 at cycle 2; out_valid=1, out_id=2, out_data=8'hA5 at cycle 3.
REQ-032 Full queue SHALL be covered: push 8'h01-8'h04 on lane 0 with no grants -> in_ready[0]=0; a fifth push of 8'h05 is dropped; draining yields 01, 02, 03, 04 in order.
REQ-033 Fairness SHALL be covered: one entry in each of lanes 0-3 with the real rr_arbiter attached -> four out_valid pulses, each out_id exactly once, gnt_err=0.
REQ-034 Spurious grant SHALL be covered: lane 0 holds one entry and the bench drives arb_gnt=3 while gnt_pending=1 -> gnt_err=1 and stays 1, no out_valid, count[0] stays 1.
REQ-035 Simultaneous push and pop SHALL be covered: lane 1 at count 1, grant to 1 in the same cycle as a push of 8'h33 -> count stays 1, the next dispatch on lane 1 is 8'h33.
REQ-036 Reset mid-operation SHALL be covered: lanes 0 and 3 each hold 2 entries, arb_rst is pulsed between edges -> outputs clear immediately, no out_valid afterwards, in_ready=4'b1111.
